// File: rtl/pic_pkg.sv
// Shared PIC16F54 constants: OPTION register bit positions, a decoded OPTION view,
// and the prescaler rate-mask helper used by the Timer0/WDT block.
package pic_pkg;

  localparam int OPT_T0CS  = 5;
  localparam int OPT_T0SE  = 4;
  localparam int OPT_PSA   = 3;
  localparam int OPT_PS_HI = 2;
  localparam int OPT_PS_LO = 0;

  typedef struct packed {
    logic       t0cs;
    logic       t0se;
    logic       psa;
    logic [2:0] ps;
  } opt_t;

  function automatic opt_t decode_opt(input logic [5:0] opt);
    opt_t o;
    o.t0cs = opt[OPT_T0CS];
    o.t0se = opt[OPT_T0SE];
    o.psa  = opt[OPT_PSA];
    o.ps   = opt[OPT_PS_HI:OPT_PS_LO];
    return o;
  endfunction

  // TMR0 side divides by 2^(PS+1), WDT side by 2^PS; a pulse fires when the masked count wraps to 0.
  function automatic logic [7:0] presc_mask(input logic psa, input logic [2:0] ps);
    logic [8:0] m;
    m = psa ? ((9'd1 << ps) - 9'd1) : ((9'd2 << ps) - 9'd1);
    return m[7:0];
  endfunction

endpackage

// File: rtl/t0cki_sync.sv
// Brings the asynchronous T0CKI pin into the clk domain and detects the selected edge.
// A pin already high when reset releases is seen as one rising edge.
module t0cki_sync (
  input  logic clk,
  input  logic rst,
  input  logic t0cki,
  input  logic t0se,
  output logic t0cki_edge
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= t0cki;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign t0cki_edge = t0se ? (~s2_q & s3_q) : (s2_q & ~s3_q);

endmodule

// File: rtl/tmr0_wdt_presc.sv
// Timer0 clock source, shared 8-bit prescaler and watchdog timebase for the PIC16F54 core.
// OPTION.PSA steers the prescaler to TMR0 (0) or to the WDT (1).
module tmr0_wdt_presc
  import pic_pkg::*;
#(
  parameter int WDT_BASE_W = 10,
  parameter int PRESC_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         option_in,
  input  logic               t0cki,
  input  logic               tmr0_wr,
  input  logic               clrwdt,
  input  logic               sleep,
  input  logic               wdt_en,
  output logic               tmr0_inc,
  output logic               wdtmr,
  output logic [PRESC_W-1:0] presc_q
);

  opt_t opt;
  logic opt_unused;
  logic t0cki_edge, tick, clr_wdt, blocked, base_to, psa_chg;
  logic [PRESC_W-1:0] presc_d, presc_inc, mask;
  logic [WDT_BASE_W-1:0] wdt_base_q, wdt_base_d;
  logic inhibit_q, inhibit_d;
  logic psa_q;
  logic tmr0_inc_q, tmr0_inc_d;
  logic wdtmr_q, wdtmr_d;

  // OPTION[7:6] belong to the port pins, not to this block.
  assign opt        = decode_opt(option_in[5:0]);
  assign opt_unused = ^option_in[7:6];

  t0cki_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .t0cki      (t0cki),
    .t0se       (opt.t0se),
    .t0cki_edge (t0cki_edge)
  );

  assign tick      = opt.t0cs ? t0cki_edge : 1'b1;
  assign clr_wdt   = clrwdt | sleep;
  assign blocked   = tmr0_wr | inhibit_q;
  assign base_to   = wdt_en & (&wdt_base_q);
  assign psa_chg   = opt.psa != psa_q;
  assign mask      = presc_mask(opt.psa, opt.ps);
  assign presc_inc = presc_q + 1'b1;

  assign wdt_base_d = (!wdt_en || clr_wdt) ? '0 : wdt_base_q + 1'b1;
  // Inhibit covers the write cycle itself plus the cycle after it.
  assign inhibit_d  = tmr0_wr;

  always_comb begin
    presc_d    = presc_q;
    tmr0_inc_d = 1'b0;
    wdtmr_d    = 1'b0;
    if (psa_chg) begin
      presc_d = '0;
    end else if (!opt.psa) begin
      if (tmr0_wr) begin
        presc_d = '0;
      end else if (tick && !blocked) begin
        presc_d    = presc_inc;
        tmr0_inc_d = (presc_inc & mask) == '0;
      end
      wdtmr_d = base_to && !clr_wdt;
    end else begin
      tmr0_inc_d = tick && !blocked;
      if (clr_wdt) begin
        presc_d = '0;
      end else if (base_to) begin
        presc_d = presc_inc;
        wdtmr_d = (presc_inc & mask) == '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      wdt_base_q <= '0;
      inhibit_q  <= 1'b0;
      psa_q      <= 1'b0;
      tmr0_inc_q <= 1'b0;
      wdtmr_q    <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      wdt_base_q <= wdt_base_d;
      inhibit_q  <= inhibit_d;
      psa_q      <= opt.psa;
      tmr0_inc_q <= tmr0_inc_d;
      wdtmr_q    <= wdtmr_d;
    end
  end

  assign tmr0_inc = tmr0_inc_q;
  assign wdtmr    = wdtmr_q;

endmodule

// File: tb/tb_tmr0_wdt_presc.sv
// Bench for tmr0_wdt_presc: directed scenarios with hand-computed expectations, then random
// stimulus, all checked every cycle against a count-based reference model.
module tb_tmr0_wdt_presc;

  localparam int BASE_W   = 4;
  localparam int BASE_MAX = (1 << BASE_W) - 1;

  logic       clk, rst;
  logic [7:0] option_in;
  logic       t0cki, tmr0_wr, clrwdt, sleep, wdt_en;
  logic       tmr0_inc, wdtmr;
  logic [7:0] presc_q;

  int cyc = 0;
  int nChecks = 0;
  int nPass = 0;
  bit chkEn = 0;

  // Reference model: counts of accepted ticks / WDT timeouts, plus the pin history.
  int mCount, mBase, mBlockLeft;
  bit mPsaPrev, mExpInc, mExpWdt;
  bit pinHist[$];

  tmr0_wdt_presc #(.WDT_BASE_W(BASE_W), .PRESC_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .option_in (option_in),
    .t0cki     (t0cki),
    .tmr0_wr   (tmr0_wr),
    .clrwdt    (clrwdt),
    .sleep     (sleep),
    .wdt_en    (wdt_en),
    .tmr0_inc  (tmr0_inc),
    .wdtmr     (wdtmr),
    .presc_q   (presc_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // The pin reaches the edge detector two clocks late; an edge is a change between the
  // samples taken three and two clocks ago.
  task automatic modelStep();
    bit psa, t0cs, t0se, rise, fall, tick, blocked, clr, timeout;
    int ps;
    psa     = option_in[3];
    t0cs    = option_in[5];
    t0se    = option_in[4];
    ps      = int'(option_in[2:0]);
    rise    = pinHist[1] && !pinHist[0];
    fall    = !pinHist[1] && pinHist[0];
    tick    = !t0cs || (t0se ? fall : rise);
    blocked = tmr0_wr || (mBlockLeft > 0);
    clr     = clrwdt || sleep;
    timeout = wdt_en && (mBase == BASE_MAX);
    mExpInc = 1'b0;
    mExpWdt = 1'b0;
    if (psa != mPsaPrev) begin
      mCount = 0;
    end else if (!psa) begin
      if (tmr0_wr) mCount = 0;
      else if (tick && !blocked) begin
        mCount  = (mCount + 1) % 256;
        mExpInc = (mCount % (2 << ps)) == 0;
      end
      mExpWdt = timeout && !clr;
    end else begin
      mExpInc = tick && !blocked;
      if (clr) mCount = 0;
      else if (timeout) begin
        mCount  = (mCount + 1) % 256;
        mExpWdt = (mCount % (1 << ps)) == 0;
      end
    end
    mBase      = (wdt_en && !clr) ? (mBase + 1) % (BASE_MAX + 1) : 0;
    mBlockLeft = tmr0_wr ? 1 : (mBlockLeft > 0 ? mBlockLeft - 1 : 0);
    mPsaPrev   = psa;
    pinHist.push_back(t0cki);
    void'(pinHist.pop_front());
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mCount = 0; mBase = 0; mBlockLeft = 0;
      mPsaPrev = 0; mExpInc = 0; mExpWdt = 0;
      pinHist = {1'b0, 1'b0, 1'b0};
    end else begin
      modelStep();
    end
  end

  always @(negedge clk) begin
    if (chkEn && !rst) begin
      checkOutput("model_tmr0_inc", {31'd0, tmr0_inc}, {31'd0, mExpInc});
      checkOutput("model_wdtmr", {31'd0, wdtmr}, {31'd0, mExpWdt});
      checkOutput("model_presc_q", {24'd0, presc_q}, mCount);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] opt, input logic en, input logic wr,
                               input logic cw, input logic slp, input logic t0);
    option_in = opt;
    wdt_en    = en;
    tmr0_wr   = wr;
    clrwdt    = cw;
    sleep     = slp;
    t0cki     = t0;
  endtask

  task automatic waitPulse(input bit selWdt, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((selWdt ? wdtmr : tmr0_inc) == 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int cnt, a, b, c0;
    rst = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    chkEn = 1'b1;
    repeat (3) step();
    checkOutput("reset_tmr0_inc", {31'd0, tmr0_inc}, 32'd0);
    checkOutput("reset_wdtmr", {31'd0, wdtmr}, 32'd0);
    checkOutput("reset_presc", {24'd0, presc_q}, 32'd0);
    rst = 1'b0;

    // TMR0 at 1:2, then 1:256 with the prescaler wrapping.
    repeat (4) step();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tmr0_inc) cnt++;
    end
    checkOutput("ps0_inc_count", cnt, 32'd10);
    applyStimulus(8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    waitPulse(1'b0, 300, a);
    repeat (255) step();
    checkOutput("ps7_presc_ff", {24'd0, presc_q}, 32'hFF);
    step();
    checkOutput("ps7_presc_wrap", {24'd0, presc_q}, 32'h00);
    checkOutput("ps7_interval", cyc - a, 32'd256);

    // External clock, rising then falling edges, pulse 3 clocks after the pin edge.
    applyStimulus(8'h28, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) step();
    for (int i = 0; i < 3; i++) begin
      t0cki = 1'b1; c0 = cyc;
      waitPulse(1'b0, 8, a);
      checkOutput("t0cki_rise_delay", a - c0, 32'd3);
      repeat (2) step();
      t0cki = 1'b0;
      repeat (5) step();
    end
    option_in = 8'h38;
    repeat (5) step();
    for (int i = 0; i < 3; i++) begin
      t0cki = 1'b1;
      repeat (5) step();
      t0cki = 1'b0; c0 = cyc;
      waitPulse(1'b0, 8, a);
      checkOutput("t0cki_fall_delay", a - c0, 32'd3);
      repeat (2) step();
    end

    // Watchdog rates and disable.
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    waitPulse(1'b1, 40, a);
    waitPulse(1'b1, 40, b);
    checkOutput("wdt_base_interval", b - a, 32'd16);
    option_in = 8'h0B;
    waitPulse(1'b1, 300, a);
    waitPulse(1'b1, 300, b);
    checkOutput("wdt_ps3_interval", b - a, 32'd128);
    wdt_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (wdtmr) cnt++;
    end
    checkOutput("wdt_disabled_count", cnt, 32'd0);

    // Periodic CLRWDT keeps the watchdog quiet.
    applyStimulus(8'h0B, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      clrwdt = 1'b1;
      step();
      checkOutput("clrwdt_presc_zero", {24'd0, presc_q}, 32'd0);
      clrwdt = 1'b0;
      for (int j = 0; j < 99; j++) begin
        step();
        if (wdtmr) cnt++;
      end
    end
    checkOutput("clrwdt_wdt_count", cnt, 32'd0);

    // TMR0 write clears the prescaler and inhibits two cycles.
    applyStimulus(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    checkOutput("wr_presc_before", {24'd0, presc_q}, 32'd2);
    tmr0_wr = 1'b1; c0 = cyc;
    step();
    checkOutput("wr_presc_cleared", {24'd0, presc_q}, 32'd0);
    checkOutput("wr_inhibit_1", {31'd0, tmr0_inc}, 32'd0);
    tmr0_wr = 1'b0;
    step();
    checkOutput("wr_inhibit_2", {31'd0, tmr0_inc}, 32'd0);
    checkOutput("wr_tick_dropped", {24'd0, presc_q}, 32'd0);
    waitPulse(1'b0, 10, a);
    checkOutput("wr_next_inc", a - c0, 32'd6);

    // Asynchronous reset in the middle of a count.
    option_in = 8'h07;
    for (int i = 0; i < 300; i++) begin
      step();
      if (presc_q == 8'h37) break;
    end
    checkOutput("find_presc_37", {24'd0, presc_q}, 32'h37);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_presc", {24'd0, presc_q}, 32'd0);
    checkOutput("async_rst_inc", {31'd0, tmr0_inc}, 32'd0);
    checkOutput("async_rst_wdt", {31'd0, wdtmr}, 32'd0);
    repeat (2) step();
    rst = 1'b0;
    repeat (5) step();
    checkOutput("rst_restart_presc", {24'd0, presc_q}, 32'd5);

    // Random traffic against the model.
    wdt_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(999) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
      if ($urandom_range(63) == 0) option_in = 8'($urandom);
      if ($urandom_range(3) == 0) t0cki = ~t0cki;
      tmr0_wr = ($urandom_range(15) == 0);
      clrwdt  = ($urandom_range(31) == 0);
      sleep   = ($urandom_range(63) == 0);
      if ($urandom_range(199) == 0) wdt_en = ~wdt_en;
    end
    step();
    chkEn = 1'b0;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
